// File: rtl/load_store_unit.sv
// RV32I memory stage: issues one data-memory transaction over a req/gnt/rvalid bus,
// handles byte lanes and load extension, and reports misaligned/illegal/timeout errors.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt;
    logic               req_bad;
    logic               bus_done;
    logic               timeout_hit;

    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        if (we)
            return f3 >= 3'd3;
        else
            return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Shift the addressed byte/half down to lane 0, then extend per funct3.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return rdata;
        endcase
    endfunction

    assign req_bad     = illegal_f3(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
    assign bus_done    = ((state == ISSUE) && mem_gnt && mem_rvalid) || ((state == WAIT) && mem_rvalid);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TMO_LAST));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req_valid) state_nxt = req_bad ? RESP : ISSUE;
            ISSUE: begin
                if (mem_gnt && mem_rvalid) state_nxt = RESP;
                else if (mem_gnt)          state_nxt = WAIT;
                else if (timeout_hit)      state_nxt = RESP;
            end
            WAIT:  if (mem_rvalid || timeout_hit) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= lane_be(req_funct3, req_addr[1:0]);
                        mem_wdata <= lane_wdata(req_funct3, req_wdata);
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        cnt       <= '0;
                        err_q     <= req_bad;
                        rdata_q   <= '0;
                    end
                end
                ISSUE, WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A bus completion in the same cycle as the timeout wins.
                    if (bus_done) begin
                        err_q   <= 1'b0;
                        rdata_q <= mem_we ? 32'd0 : load_extract(f3_q, off_q, mem_rdata);
                    end else if (state_nxt == RESP) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_req   = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lanes, extension, latency, errors, timeout, async reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Bus modes: 0 = gnt+rvalid together, 1 = gnt then rvalid next cycle, 2 = never grant.
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int mode, input logic [31:0] rd,
                         output int lat, output logic [31:0] o_rdata, output logic o_err,
                         output logic saw_req, output logic stable, output logic [31:0] o_addr,
                         output logic [3:0] o_be, output logic [31:0] o_wdata, output logic o_we);
        bit granted = 0;
        bit done = 0;
        lat = -1; o_rdata = 32'hxxxxxxxx; o_err = 1'bx;
        saw_req = 0; stable = 1; o_addr = 0; o_be = 0; o_wdata = 0; o_we = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_rdata = rd;
        @(posedge clk);
        #1 req_valid = 0;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = n; o_rdata = rsp_rdata; o_err = rsp_err; done = 1;
                mem_gnt = 0; mem_rvalid = 0;
            end else begin
                if (mem_req) begin
                    if (!saw_req) begin
                        o_addr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_we = mem_we;
                    end else if (mem_addr !== o_addr || mem_be !== o_be ||
                                 mem_wdata !== o_wdata || mem_we !== o_we) begin
                        stable = 0;
                    end
                    saw_req = 1;
                end
                mem_gnt = 0; mem_rvalid = 0;
                if (mode != 2) begin
                    if (mem_req && !granted) begin
                        mem_gnt = 1; mem_rvalid = (mode == 0); granted = 1;
                    end else if (granted) begin
                        mem_rvalid = 1;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_req_we got=%b%b exp=00", mem_req, mem_we); end
        total++; if (mem_addr !== 32'd0 || mem_be !== 4'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem_fields got=%h/%b/%h exp=0", mem_addr, mem_be, mem_wdata); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp got=%b/%b/%h exp=0", rsp_valid, rsp_err, rsp_rdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        do_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h0, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (a !== 32'h100 || be !== 4'b1111 || wd !== 32'hDEADBEEF || we !== 1'b1) begin bad++; $display("FAIL sw_bus got=%h/%b/%h/%b exp=00000100/1111/deadbeef/1", a, be, wd, we); end
        total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        total++; if (e !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sw_rsp got=%b/%h exp=0/00000000", e, rd); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL sw_one_pulse got=%b/%b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_loads();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        do_op(1'b0, 3'd0, 32'h203, 32'h0, 1, 32'h80FF1234, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin bad++; $display("FAIL lb got=%h/%b exp=ffffff80/0", rd, e); end
        total++; if (a !== 32'h200 || be !== 4'b1000 || we !== 1'b0) begin bad++; $display("FAIL lb_bus got=%h/%b/%b exp=00000200/1000/0", a, be, we); end
        do_op(1'b0, 3'd4, 32'h203, 32'h0, 1, 32'h80FF1234, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
        do_op(1'b0, 3'd1, 32'h202, 32'h0, 1, 32'h80FF1234, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'hFFFF80FF || be !== 4'b1100) begin bad++; $display("FAIL lh got=%h/%b exp=ffff80ff/1100", rd, be); end
        do_op(1'b0, 3'd5, 32'h202, 32'h0, 0, 32'h80FF1234, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'h000080FF || lat !== 2) begin bad++; $display("FAIL lhu got=%h/lat%0d exp=000080ff/lat2", rd, lat); end
        do_op(1'b0, 3'd2, 32'h200, 32'h0, 1, 32'h80FF1234, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'h80FF1234 || be !== 4'b1111) begin bad++; $display("FAIL lw got=%h/%b exp=80ff1234/1111", rd, be); end
        do_op(1'b0, 3'd0, 32'h201, 32'h0, 1, 32'h00007F00, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (rd !== 32'h0000007F || be !== 4'b0010) begin bad++; $display("FAIL lb_pos got=%h/%b exp=0000007f/0010", rd, be); end
    endtask

    task automatic test_store_half();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        do_op(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 0, 32'h0, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (a !== 32'h100 || be !== 4'b1100 || wd !== 32'hABCDABCD) begin bad++; $display("FAIL sh_bus got=%h/%b/%h exp=00000100/1100/abcdabcd", a, be, wd); end
        total++; if (lat !== 2 || e !== 1'b0) begin bad++; $display("FAIL sh_latency got=%0d/%b exp=2/0", lat, e); end
        do_op(1'b1, 3'd0, 32'h101, 32'h12345678, 0, 32'h0, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (be !== 4'b0010 || wd !== 32'h78787878) begin bad++; $display("FAIL sb_bus got=%b/%h exp=0010/78787878", be, wd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        do_op(1'b0, 3'd2, 32'h102, 32'h0, 0, 32'h11223344, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (sr !== 1'b0 || lat !== 1 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lw_misaligned got=req%b/lat%0d/err%b/%h exp=req0/lat1/err1/0", sr, lat, e, rd); end
        do_op(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'h11223344, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (sr !== 1'b0 || lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL load_f3_3 got=req%b/lat%0d/err%b exp=req0/lat1/err1", sr, lat, e); end
        do_op(1'b1, 3'd3, 32'h100, 32'h5, 0, 32'h0, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (sr !== 1'b0 || e !== 1'b1) begin bad++; $display("FAIL store_f3_3 got=req%b/err%b exp=req0/err1", sr, e); end
        do_op(1'b0, 3'd1, 32'h201, 32'h0, 0, 32'h11223344, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (sr !== 1'b0 || e !== 1'b1) begin bad++; $display("FAIL lh_misaligned got=req%b/err%b exp=req0/err1", sr, e); end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        bit late_seen = 0;
        do_op(1'b0, 3'd2, 32'h300, 32'h0, 2, 32'h0, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (sr !== 1'b1 || st !== 1'b1 || a !== 32'h300) begin bad++; $display("FAIL tmo_req_hold got=req%b/stable%b/%h exp=1/1/00000300", sr, st, a); end
        total++; if (lat !== 256 || e !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL tmo_resp got=lat%0d/err%b/%h exp=lat256/err1/0", lat, e, rd); end
        @(negedge clk);
        total++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL tmo_idle got=req%b/rdy%b exp=0/1", mem_req, req_ready); end
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) late_seen = 1;
        end
        mem_rvalid = 0;
        total++; if (late_seen) begin bad++; $display("FAIL late_rvalid got=reacted exp=ignored"); end
        do_op(1'b0, 3'd2, 32'h304, 32'h0, 1, 32'hCAFEF00D, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (lat !== 3 || e !== 1'b0 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL after_tmo got=lat%0d/err%b/%h exp=lat3/err0/cafef00d", lat, e, rd); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, a, wd; logic e, sr, st, we; logic [3:0] be;
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'd2; req_addr = 32'h400; req_wdata = 0;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_issue got=%b exp=1", mem_req); end
        mem_gnt = 1;
        @(posedge clk);
        #1 mem_gnt = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_wait_busy got=%b exp=1", busy); end
        #1 rst_n = 0;
        #1;
        total++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_async_reset got=req%b/vld%b/rdy%b/busy%b exp=0/0/1/0", mem_req, rsp_valid, req_ready, busy); end
        @(negedge clk);
        rst_n = 1;
        do_op(1'b0, 3'd4, 32'h001, 32'h0, 1, 32'h0000AB00, lat, rd, e, sr, st, a, be, wd, we);
        total++; if (lat !== 3 || e !== 1'b0 || rd !== 32'h000000AB) begin bad++; $display("FAIL post_reset_op got=lat%0d/err%b/%h exp=lat3/err0/000000ab", lat, e, rd); end
    endtask

    initial begin
        rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
